// File: rtl/ysyx_25060170_dmem_resp.sv
// Data-memory responder: fixed-latency load/store on a word array.
// Optional: YSYX_25060170_DMEM_RAND_DELAY_EN adds 0..3 random wait cycles.
module ysyx_25060170_dmem_resp #(
  parameter int          DEPTH_W   = 10,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_len,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [32:0] SPAN   = 33'd4 << DEPTH_W;
  localparam logic [4:0]  LAT_M1 = 5'(LATENCY - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] len_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [2**DEPTH_W];

  logic [31:0]        off;
  logic [1:0]         lane;
  logic [DEPTH_W-1:0] idx;
  logic               len_b;
  logic               len_h;
  logic               len_w;
  logic               oob;
  logic               err;
  logic [31:0]        word;
  logic [31:0] rsh;
  logic [31:0] ld;
  logic [31:0] wsh;
  logic [3:0]  be;
  logic        fire;
  logic        commit;

  assign req_ready = rst_n && (state == IDLE);

  assign off   = addr_q - BASE_ADDR;
  assign lane  = off[1:0];
  assign idx   = off[DEPTH_W+1:2];
  assign len_b = (len_q == 32'd1);
  assign len_h = (len_q == 32'd2);
  assign len_w = (len_q == 32'd4);
  // Addresses below BASE_ADDR wrap to a huge offset and fail here too
  assign oob   = {1'b0, off} >= SPAN;
  assign err   = oob
               || !(len_b || len_h || len_w)
               || (len_h && off[0])
               || (len_w && (off[1:0] != 2'b00));

  assign word = mem[idx];
  assign rsh  = word >> {lane, 3'b000};
  assign wsh  = wdata_q << {lane, 3'b000};

  always_comb begin
    ld = 32'h0;
    be = 4'h0;
    unique case (1'b1)
      len_b: begin
        ld = {24'h0, rsh[7:0]};
        be = 4'b0001 << lane;
      end
      len_h: begin
        ld = {16'h0, rsh[15:0]};
        be = 4'b0011 << lane;
      end
      len_w: begin
        ld = rsh;
        be = 4'b1111;
      end
      default: begin
        ld = 32'h0;
        be = 4'h0;
      end
    endcase
  end

  assign fire   = (state == WAIT) && (cnt == 5'd0);
  assign commit = fire && wen_q && !err;

`ifdef YSYX_25060170_DMEM_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic       fb;

  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else if (req_valid && req_ready) begin
      lfsr <= {lfsr[6:0], fb};
    end
  end

  logic [4:0] lat_ld;
  assign lat_ld = LAT_M1 + {3'b000, lfsr[1:0]};
`else
  logic [4:0] lat_ld;
  assign lat_ld = LAT_M1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      wen_q     <= 1'b0;
      addr_q    <= 32'h0;
      len_q     <= 32'h0;
      wdata_q   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wen_q   <= req_wen;
            addr_q  <= req_addr;
            len_q   <= req_len;
            wdata_q <= req_wdata;
            cnt     <= lat_ld;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 5'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || wen_q) ? 32'h0 : ld;
            state     <= RESP;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; a dropped WAIT never reaches commit
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_dmem_resp.sv
// Directed scoreboard bench for ysyx_25060170_dmem_resp.
// Expected responses are queued at request time and popped on response.
module tb_ysyx_25060170_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_len = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int pass_cnt = 0;
  int total = 0;
  logic [32:0] sb [$];

  ysyx_25060170_dmem_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic xact(input logic        wen,
                      input logic [31:0] addr,
                      input logic [31:0] len,
                      input logic [31:0] wdata,
                      input logic        exp_err,
                      input logic [31:0] exp_data,
                      input int          hold);
    int n;
    logic [32:0] e;
    logic [31:0] d0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wdata;
    sb.push_back({exp_err, exp_data});
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rsp_valid && n < 50);
    check("latency", n, 2);
    e = sb.pop_front();
    check("rdata", rsp_rdata, e[31:0]);
    check("err", {31'h0, rsp_err}, {31'h0, e[32]});
    d0 = rsp_rdata;
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("hold_rdata", rsp_rdata, d0);
      check("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("valid_drop", {31'h0, rsp_valid}, 32'h0);
    check("req_ready_back", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #2;
    check("rst_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'h0, rsp_err}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    xact(1, 32'h8000_0010, 4, 32'hDEAD_BEEF, 0, 32'h0, 0);
    xact(0, 32'h8000_0010, 4, 32'h0, 0, 32'hDEAD_BEEF, 0);

    xact(1, 32'h8000_0013, 1, 32'hFFFF_FF5A, 0, 32'h0, 0);
    xact(0, 32'h8000_0010, 4, 32'h0, 0, 32'h5AAD_BEEF, 0);
    xact(0, 32'h8000_0012, 2, 32'h0, 0, 32'h0000_5AAD, 0);
    xact(0, 32'h8000_0013, 1, 32'h0, 0, 32'h0000_005A, 0);

    xact(0, 32'h8000_0012, 4, 32'h0, 1, 32'h0, 0);
    xact(1, 32'h8000_0010, 3, 32'h1111_1111, 1, 32'h0, 0);
    xact(0, 32'h7FFF_FFFC, 4, 32'h0, 1, 32'h0, 0);
    xact(0, 32'h8000_0011, 2, 32'h0, 1, 32'h0, 0);
    xact(0, 32'h8000_0010, 4, 32'h0, 0, 32'h5AAD_BEEF, 5);

    xact(1, 32'h8000_0020, 4, 32'hCAFE_F00D, 0, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_len   = 32'd4;
    req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'h0, rsp_valid}, 32'h0);
    check("abort_rdata", rsp_rdata, 32'h0);
    check("abort_err", {31'h0, rsp_err}, 32'h0);
    check("abort_req_ready", {31'h0, req_ready}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    xact(0, 32'h8000_0020, 4, 32'h0, 0, 32'hCAFE_F00D, 0);

    xact(1, 32'h8000_0FFC, 4, 32'hA1B2_C3D4, 0, 32'h0, 0);
    xact(0, 32'h8000_0FFC, 4, 32'h0, 0, 32'hA1B2_C3D4, 0);
    xact(0, 32'h8000_0FFE, 2, 32'h0, 0, 32'h0000_A1B2, 0);
    xact(0, 32'h8000_1000, 4, 32'h0, 1, 32'h0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
